// File: rtl/pulse_rate_counter.sv
// Gated pulse-rate counter: counts synchronized pulse_in rising edges over a
// 2^(10+2*gate_sel) cycle window. Define GLITCH_FILTER_EN to reject 1-cycle pulses.
module pulse_rate_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             pulse_in,
    input  logic [2:0]       gate_sel,
    output logic [CNT_W-1:0] rate,
    output logic             rate_valid,
    output logic             overflow,
    output logic             active
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    localparam int TMR_W = 25;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [TMR_W-1:0] TMR_ONE = {{(TMR_W-1){1'b0}}, 1'b1};

    function automatic logic [TMR_W-1:0] window_len(input logic [2:0] sel);
        window_len = TMR_ONE << (5'd10 + {1'b0, sel, 1'b0});
    endfunction

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q, prev_d;
    logic edge_q, edge_d;
`ifdef GLITCH_FILTER_EN
    logic prev2_q, prev2_d;
`endif

    state_t           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] counter_q, counter_d;
    logic [CNT_W-1:0] rate_q, rate_d;
    logic             rate_valid_q, rate_valid_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] count_now;

    // Synchronizer and edge-detect pipeline
    always_comb begin
        sync1_d = pulse_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
`ifdef GLITCH_FILTER_EN
        prev2_d = prev_q;
        edge_d  = sync2_q & prev_q & ~prev2_q;
`else
        edge_d  = sync2_q & ~prev_q;
`endif
    end

    // Window FSM, saturating counter and result capture
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        counter_d    = counter_q;
        rate_d       = rate_q;
        rate_valid_d = 1'b0;
        overflow_d   = overflow_q;
        if (edge_q && (counter_q != CNT_MAX)) begin
            count_now = counter_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_now = counter_q;
        end

        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d   = COUNT;
                    timer_d   = window_len(gate_sel);
                    counter_d = {CNT_W{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            COUNT: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (timer_q == TMR_ONE) begin
                    // Final cycle: publish and restart with no dead cycle
                    rate_d       = count_now;
                    rate_valid_d = 1'b1;
                    overflow_d   = (count_now == CNT_MAX);
                    timer_d      = window_len(gate_sel);
                    counter_d    = {CNT_W{1'b0}};
                end else begin
                    timer_d   = timer_q - TMR_ONE;
                    counter_d = count_now;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            prev_q       <= 1'b0;
            edge_q       <= 1'b0;
`ifdef GLITCH_FILTER_EN
            prev2_q      <= 1'b0;
`endif
            state_q      <= IDLE;
            timer_q      <= {TMR_W{1'b0}};
            counter_q    <= {CNT_W{1'b0}};
            rate_q       <= {CNT_W{1'b0}};
            rate_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            prev_q       <= prev_d;
            edge_q       <= edge_d;
`ifdef GLITCH_FILTER_EN
            prev2_q      <= prev2_d;
`endif
            state_q      <= state_d;
            timer_q      <= timer_d;
            counter_q    <= counter_d;
            rate_q       <= rate_d;
            rate_valid_q <= rate_valid_d;
            overflow_q   <= overflow_d;
        end
    end

    assign rate       = rate_q;
    assign rate_valid = rate_valid_q;
    assign overflow   = overflow_q;
    assign active     = (state_q == COUNT);

endmodule

// File: tb/tb_pulse_rate_counter.sv
// Directed bench for pulse_rate_counter (CNT_W=8) with an expected-result queue.
module tb_pulse_rate_counter;

    localparam int CW = 8;
    localparam int SAT = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic          en;
    logic          pulse_in;
    logic [2:0]    gate_sel;
    logic [CW-1:0] rate;
    logic          rate_valid;
    logic          overflow;
    logic          active;

    pulse_rate_counter #(.CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .pulse_in   (pulse_in),
        .gate_sel   (gate_sel),
        .rate       (rate),
        .rate_valid (rate_valid),
        .overflow   (overflow),
        .active     (active)
    );

    typedef struct {
        int rate;
        int ovf;
        int at;
    } exp_t;

    exp_t sb_q[$];
    int   vectors    = 0;
    int   miscompares = 0;
    int   cyc        = 0;
    int   period     = 0;
    int   high       = 0;
    int   noise      = 0;
    int   ph         = 0;
    int   k;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected edges per window from the stimulus pattern
    function automatic int exp_count(input int len, input int per, input int nz);
        int c;
        c = (per == 0) ? 0 : len / per;
`ifndef GLITCH_FILTER_EN
        if (nz != 0) c = c + len / 32;
`endif
        return (c > SAT) ? SAT : c;
    endfunction

    task automatic push(input int len, input int at);
        exp_t e;
        e.rate = exp_count(len, period, noise);
        e.ovf  = (e.rate == SAT) ? 1 : 0;
        e.at   = at;
        sb_q.push_back(e);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", sb_q.size(), 0);
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Start a measurement at the next edge; returns that edge number
    task automatic start_en(output int kk);
        @(negedge clk);
        en = 1'b1;
        kk = cyc + 1;
    endtask

    // Pulse generator: period/high stream plus optional 1-cycle noise in low phase
    initial begin
        pulse_in = 1'b0;
        forever begin
            @(negedge clk);
            ph++;
            pulse_in = ((period != 0) && ((ph % period) < high)) ||
                       ((noise != 0) && ((ph % 32) == 5));
        end
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rate_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("spurious_rate_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("rate", rate, e.rate);
                check("overflow", overflow, e.ovf);
                check("rv_cycle", cyc, e.at);
            end
        end
    end

    initial begin
        rst = 1'b1;
        en = 1'b0;
        gate_sel = 3'd0;
        period = 8;
        high = 2;
        settle(5);
        check("rst_rate", rate, 0);
        check("rst_rate_valid", rate_valid, 0);
        check("rst_overflow", overflow, 0);
        check("rst_active", active, 0);
        rst = 1'b0;
        settle(10);
        check("idle_active", active, 0);

        // Back-to-back windows, then drop en mid-window
        start_en(k);
        push(1024, k + 1024);
        push(1024, k + 2048);
        push(1024, k + 3072);
        settle(3);
        check("count_active", active, 1);
        wait_cyc(k + 3072 + 500);
        check("three_windows_seen", sb_q.size(), 0);
        en = 1'b0;
        @(negedge clk);
        check("drop_active", active, 0);
        check("drop_rate_hold", rate, 128);
        settle(1100);
        check("drop_idle_active", active, 0);

        // Saturation, then recovery
        period = 4;
        settle(10);
        start_en(k);
        push(1024, k + 1024);
        wait_drain(2000);
        en = 1'b0;
        period = 8;
        settle(10);
        start_en(k);
        push(1024, k + 1024);
        wait_drain(2000);
        en = 1'b0;
        settle(2);
        check("recover_overflow", overflow, 0);

        // gate_sel change mid-window takes effect next window
        settle(10);
        start_en(k);
        push(1024, k + 1024);
        wait_cyc(k + 300);
        gate_sel = 3'd1;
        push(4096, k + 1024 + 4096);
        wait_drain(6000);
        en = 1'b0;
        gate_sel = 3'd0;

        // Noise pulses in the low phase
        noise = 1;
        settle(10);
        start_en(k);
        push(1024, k + 1024);
        push(1024, k + 2048);
        wait_drain(3000);
        en = 1'b0;

        // Reset mid-window on a quiet input
        noise = 0;
        period = 0;
        settle(10);
        start_en(k);
        wait_cyc(k + 700);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_rate", rate, 0);
        check("midrst_rate_valid", rate_valid, 0);
        check("midrst_overflow", overflow, 0);
        check("midrst_active", active, 0);
        rst = 1'b0;
        push(1024, k + 702 + 1024);
        wait_drain(2000);
        en = 1'b0;
        settle(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
